// File: rtl/crc8_pkg.sv
// crc8_pkg: CRC-8 (poly 0x07, init 0x00, MSB-first) parameters and byte-wide update shared by generator and checker
package crc8_pkg;
  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;
  typedef logic [CRC_W-1:0] crc_t;
  function automatic crc_t crc8_update(input crc_t crc, input logic [7:0] data);
    crc_t c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[CRC_W-1] ? (c << 1) ^ CRC_POLY : c << 1;
    return c;
  endfunction
endpackage

// File: rtl/crc_chk.sv
// crc_chk: runs the CRC over the channel stream and flags the frame good when the residue is zero at window end
// ports: clk, reset (async, active-low), data_out, data_read2 (check window) -> data_crc_out2 (residue), valid
module crc_chk
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_out,
  input  logic       data_read2,
  output logic [7:0] data_crc_out2,
  output logic       valid
);
  crc_t r_res;
  logic r_prev;
  logic r_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_res   <= CRC_INIT;
      r_prev  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_prev  <= data_read2;
      r_res   <= data_read2 ? crc8_update(r_res, data_out) : CRC_INIT;
      r_valid <= data_read2 ? 1'b0 : (r_prev ? (r_res == '0) : r_valid);
    end
  assign data_crc_out2 = r_res;
  assign valid         = r_valid;
endmodule

// File: rtl/crc_gen.sv
// crc_gen: forwards payload bytes one cycle late, then emits the frame CRC with a one-cycle data_ready pulse
// ports: clk, reset (async, active-low), data_in, data_read1 (frame enable) -> data_crc_out, data_ready
module crc_gen
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_read1,
  output logic [7:0] data_crc_out,
  output logic       data_ready
);
  crc_t       r_crc;
  logic       r_prev;
  logic [7:0] r_out;
  logic       r_rdy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_crc  <= CRC_INIT;
      r_prev <= 1'b0;
      r_out  <= 8'h00;
      r_rdy  <= 1'b0;
    end else begin
      r_prev <= data_read1;
      r_crc  <= data_read1 ? crc8_update(r_crc, data_in) : CRC_INIT;
      r_out  <= data_read1 ? data_in : (r_prev ? r_crc : 8'h00);
      r_rdy  <= !data_read1 && r_prev;
    end
  assign data_crc_out = r_out;
  assign data_ready   = r_rdy;
endmodule

// File: rtl/error_inj.sv
// error_inj: registers the generator stream, flipping bit 0 of each byte while error is set
// ports: clk, reset (async, active-low), data_crc_out, error -> data_out
module error_inj (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_crc_out,
  input  logic       error,
  output logic [7:0] data_out
);
  logic [7:0] r_out;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_out <= 8'h00;
    else        r_out <= data_crc_out ^ {7'b0, error};
  assign data_out = r_out;
endmodule

// File: rtl/crc8_link.sv
// crc8_link: CRC-8 generator -> error injector -> checker link, two cycles source to checker
// ports: clk, reset (async, active-low), data_in, data_read1, data_read2, error
//        -> data_crc_out, data_ready, data_out, data_crc_out2, valid
module crc8_link (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_read1,
  input  logic       data_read2,
  input  logic       error,
  output logic [7:0] data_crc_out,
  output logic       data_ready,
  output logic [7:0] data_out,
  output logic [7:0] data_crc_out2,
  output logic       valid
);
  logic [7:0] w_dco;
  logic [7:0] w_dout;
  crc_gen u_gen (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_read1   (data_read1),
    .data_crc_out (w_dco),
    .data_ready   (data_ready)
  );
  error_inj u_inj (
    .clk          (clk),
    .reset        (reset),
    .data_crc_out (w_dco),
    .error        (error),
    .data_out     (w_dout)
  );
  crc_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .data_out      (w_dout),
    .data_read2    (data_read2),
    .data_crc_out2 (data_crc_out2),
    .valid         (valid)
  );
  assign data_crc_out = w_dco;
  assign data_out     = w_dout;
endmodule

// File: tb/tb_crc8_link.sv
// tb_crc8_link: scoreboard bench for the CRC-8 link
module tb_crc8_link;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_read1 = 1'b0;
  logic       data_read2 = 1'b0;
  logic       error = 1'b0;
  logic [7:0] data_crc_out;
  logic       data_ready;
  logic [7:0] data_out;
  logic [7:0] data_crc_out2;
  logic       valid;

  crc8_link dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_read1    (data_read1),
    .data_read2    (data_read2),
    .error         (error),
    .data_crc_out  (data_crc_out),
    .data_ready    (data_ready),
    .data_out      (data_out),
    .data_crc_out2 (data_crc_out2),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dco;
    logic       rdy;
    logic [7:0] dout;
    logic [7:0] res;
    logic       valid;
  } exp_t;

  exp_t       q[$];
  logic [7:0] got_crc[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc_n = 0;

  logic [7:0] m_crc = 8'h00, m_dco = 8'h00, m_dout = 8'h00, m_res = 8'h00;
  logic       m_prev1 = 1'b0, m_prev2 = 1'b0, m_valid = 1'b0;

  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_crc = 8'h00; m_dco = 8'h00; m_dout = 8'h00; m_res = 8'h00;
    m_prev1 = 1'b0; m_prev2 = 1'b0; m_valid = 1'b0;
  endtask

  task automatic cyc(input logic [7:0] din, input logic rd1, input logic rd2, input logic err);
    exp_t e;
    @(negedge clk);
    data_in = din; data_read1 = rd1; data_read2 = rd2; error = err;
    e.dco   = rd1 ? din : (m_prev1 ? m_crc : 8'h00);
    e.rdy   = !rd1 && m_prev1;
    e.dout  = m_dco ^ {7'b0, err};
    e.res   = rd2 ? crc8_ref(m_res, m_dout) : 8'h00;
    e.valid = rd2 ? 1'b0 : (m_prev2 ? (m_res == 8'h00) : m_valid);
    m_crc   = rd1 ? crc8_ref(m_crc, din) : 8'h00;
    m_prev1 = rd1; m_prev2 = rd2;
    m_dco = e.dco; m_dout = e.dout; m_res = e.res; m_valid = e.valid;
    q.push_back(e);
  endtask

  // bytes packed MSB-first: byte 0 sits in the top occupied byte of the vector
  task automatic frame(input logic [127:0] bytes, input int n, input logic err, input int extra);
    for (int c = 0; c < n + 4 + extra; c++) begin
      logic [7:0] b;
      b = (c < n) ? bytes[8*(n-1-c) +: 8] : 8'h00;
      cyc(b, c < n, (c >= 1) && (c < n + 3 + extra), err);
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [7:0] crc_of(input logic [127:0] bytes, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 0; c < n; c++) r = crc8_ref(r, bytes[8*(n-1-c) +: 8]);
    return r;
  endfunction

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    cyc_n++;
    if (data_ready === 1'b1) got_crc.push_back(data_crc_out);
    if (q.size() != 0) begin
      e = q.pop_front();
      checks += 5;
      if (data_crc_out !== e.dco) begin errors++; $display("FAIL sb_data_crc_out cyc %0d: got %h want %h", cyc_n, data_crc_out, e.dco); end
      if (data_ready !== e.rdy) begin errors++; $display("FAIL sb_data_ready cyc %0d: got %b want %b", cyc_n, data_ready, e.rdy); end
      if (data_out !== e.dout) begin errors++; $display("FAIL sb_data_out cyc %0d: got %h want %h", cyc_n, data_out, e.dout); end
      if (data_crc_out2 !== e.res) begin errors++; $display("FAIL sb_data_crc_out2 cyc %0d: got %h want %h", cyc_n, data_crc_out2, e.res); end
      if (valid !== e.valid) begin errors++; $display("FAIL sb_valid cyc %0d: got %b want %b", cyc_n, valid, e.valid); end
    end
  end

  task automatic test_reset();
    #3;
    checks += 5;
    if (data_crc_out !== 8'h00) begin errors++; $display("FAIL reset_dco: got %h want 00", data_crc_out); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", data_ready); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
    if (data_crc_out2 !== 8'h00) begin errors++; $display("FAIL reset_res: got %h want 00", data_crc_out2); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    @(posedge clk); #2;
    reset = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    got_crc.delete();
    frame(128'h01, 1, 1'b0, 0);
    checks += 4;
    if (got_crc.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", got_crc.size()); end
    else if (got_crc[0] !== 8'h07) begin errors++; $display("FAIL single_crc: got %h want 07", got_crc[0]); end
    if (data_crc_out2 !== 8'h00) begin errors++; $display("FAIL single_res: got %h want 00", data_crc_out2); end
    if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL single_rdy_idle: got %b want 0", data_ready); end
  endtask

  task automatic test_check_value();
    got_crc.delete();
    frame(128'h313233343536373839, 9, 1'b0, 0);
    checks += 2;
    if (got_crc.size() != 1 || got_crc[0] !== 8'hF4) begin errors++; $display("FAIL check_value_crc: got %0d pulses first %h want 1 pulse F4", got_crc.size(), got_crc.size() ? got_crc[0] : 8'hxx); end
    if (valid !== 1'b1) begin errors++; $display("FAIL check_value_valid: got %b want 1", valid); end
  endtask

  task automatic test_error();
    got_crc.delete();
    frame(128'h123456789ABCDE, 7, 1'b1, 0);
    checks += 3;
    if (got_crc.size() != 1 || got_crc[0] !== crc_of(128'h123456789ABCDE, 7)) begin errors++; $display("FAIL error_gen_crc: got %0d pulses first %h want %h", got_crc.size(), got_crc.size() ? got_crc[0] : 8'hxx, crc_of(128'h123456789ABCDE, 7)); end
    if (valid !== 1'b0) begin errors++; $display("FAIL error_valid: got %b want 0", valid); end
    if (data_crc_out2 !== 8'h00) begin errors++; $display("FAIL error_res_cleared: got %h want 00", data_crc_out2); end
  endtask

  task automatic test_clean_after_error();
    frame(128'h1222567A9ABCDC, 7, 1'b0, 0);
    checks += 1;
    if (valid !== 1'b1) begin errors++; $display("FAIL after_error_valid: got %b want 1", valid); end
  endtask

  task automatic test_mid_reset();
    cyc(8'h12, 1'b1, 1'b0, 1'b0);
    cyc(8'h34, 1'b1, 1'b1, 1'b0);
    cyc(8'h56, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();
    data_in = 8'h00; data_read1 = 1'b0; data_read2 = 1'b0; error = 1'b0;
    #1;
    checks += 5;
    if (data_crc_out !== 8'h00) begin errors++; $display("FAIL midreset_dco: got %h want 00", data_crc_out); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL midreset_rdy: got %b want 0", data_ready); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h want 00", data_out); end
    if (data_crc_out2 !== 8'h00) begin errors++; $display("FAIL midreset_res: got %h want 00", data_crc_out2); end
    if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", valid); end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    frame(128'hA55A0F, 3, 1'b0, 0);
    checks += 1;
    if (valid !== 1'b1) begin errors++; $display("FAIL midreset_next_valid: got %b want 1", valid); end
  endtask

  task automatic test_trailing_zero();
    got_crc.delete();
    frame(128'h80, 1, 1'b0, 2);
    checks += 2;
    if (got_crc.size() != 1 || got_crc[0] !== 8'h89) begin errors++; $display("FAIL trailing_crc: got %0d pulses first %h want 1 pulse 89", got_crc.size(), got_crc.size() ? got_crc[0] : 8'hxx); end
    if (valid !== 1'b1) begin errors++; $display("FAIL trailing_valid: got %b want 1", valid); end
  endtask

  task automatic test_back_to_back();
    got_crc.delete();
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h80, 1'b1, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checks += 2;
    if (got_crc.size() != 2 || got_crc[0] !== 8'h07 || got_crc[1] !== 8'h89) begin errors++; $display("FAIL b2b_crcs: got %0d pulses want 2 pulses 07 then 89", got_crc.size()); end
    if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_check_value();
    test_error();
    test_clean_after_error();
    test_mid_reset();
    test_trailing_zero();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expectations left want 0", q.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
